// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
//   Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//   Sign handling: the unit works on operand magnitudes and fixes the result signs at the end.
// Ports:
//   clk   in  1      clock, all state updates on posedge
//   reset in  1      asynchronous, active-high; clears all state
//   start in  1      launch op, sampled only while idle
//   op    in  3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//   a     in  WIDTH  multiplicand / dividend / MTHI-MTLO source
//   b     in  WIDTH  multiplier / divisor
//   busy  out 1      high while an iterative op is in progress (RUN and FIN)
//   done  out 1      one-cycle pulse when hi/lo take a MULT/DIV result
//   hi    out WIDTH  HI register: upper product or remainder
//   lo    out WIDTH  LO register: lower product or quotient
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Shared shadow registers:
  //   multiply: acc_hi = partial upper product, acc_lo = multiplier shifting out / product low half
  //   divide:   acc_hi = partial remainder,     acc_lo = dividend shifting out / quotient
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;     // original dividend, used for divide-by-zero result
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d; // negate product / quotient
  logic              neg_rem_q, neg_rem_d; // negate remainder (dividend was negative)
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH:0]    mul_sum_s;
  logic [WIDTH-1:0]  mul_hi_s, mul_lo_s;
  logic [WIDTH:0]    div_shift_s;
  logic              div_ge_s;
  logic [WIDTH-1:0]  div_hi_s, div_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic              sgn_a_s, sgn_b_s;
  logic [WIDTH-1:0]  mag_a_s, mag_b_s;

  // Operand sign/magnitude extraction at launch; unsigned ops treat operands as non-negative.
  always_comb begin
    sgn_a_s = (op == OP_MULT || op == OP_DIV) ? a[WIDTH-1] : 1'b0;
    sgn_b_s = (op == OP_MULT || op == OP_DIV) ? b[WIDTH-1] : 1'b0;
    mag_a_s = sgn_a_s ? neg_w(a) : a;
    mag_b_s = sgn_b_s ? neg_w(b) : b;
  end

  // One multiply iteration: conditionally add multiplicand to upper half, shift right.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_s  = mul_sum_s[WIDTH:1];
    mul_lo_s  = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
    prod_s    = neg_res_q ? neg_2w({mul_hi_s, mul_lo_s}) : {mul_hi_s, mul_lo_s};
  end

  // One restoring-divide iteration: shift in next dividend bit, subtract if it fits.
  always_comb begin
    div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    // When the subtraction happens the result is below the divisor, so WIDTH bits suffice.
    if (div_ge_s) begin
      div_hi_s = div_shift_s[WIDTH-1:0] - opnd_q;
    end else begin
      div_hi_s = div_shift_s[WIDTH-1:0];
    end
    div_lo_s = {acc_lo_q[WIDTH-2:0], div_ge_s};
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = op[1];
              neg_res_d = sgn_a_s ^ sgn_b_s;
              neg_rem_d = sgn_a_s;
              div0_d    = (b == {WIDTH{1'b0}});
              a_raw_d   = a;
              acc_hi_d  = {WIDTH{1'b0}};
              acc_lo_d  = op[1] ? mag_a_s : mag_b_s;
              opnd_d    = op[1] ? mag_b_s : mag_a_s;
              cnt_d     = CNT_INIT;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_hi_d = is_div_q ? div_hi_s : mul_hi_s;
        acc_lo_d = is_div_q ? div_lo_s : mul_lo_s;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == {CW{1'b0}}) begin
          // Final iteration: commit the sign-corrected result so it is visible during FIN.
          state_d = S_FIN;
          if (is_div_q) begin
            if (div0_q) begin
              hi_d = a_raw_q;
              lo_d = {WIDTH{1'b1}};
            end else begin
              hi_d = neg_rem_q ? neg_w(div_hi_s) : div_hi_s;
              lo_d = neg_res_q ? neg_w(div_lo_s) : div_lo_s;
            end
          end else begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_hi_q  <= {WIDTH{1'b0}};
      acc_lo_q  <= {WIDTH{1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      a_raw_q   <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  // Bench-side expectation of the architectural HI/LO contents.
  logic [W-1:0] mdl_hi;
  logic [W-1:0] mdl_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on 64-bit values.
  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint       sx, sy, q, r;
    logic [63:0]  p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = 32'h0;
    rl = 32'h0;
    case (o)
      3'b001: begin
        p  = {32'h0, x} * {32'h0, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      3'b000: begin
        p  = 64'(sx * sy);
        rh = p[63:32];
        rl = p[31:0];
      end
      3'b011: begin
        if (y == 32'h0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      3'b010: begin
        if (y == 32'h0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rh = 32'h0;
          rl = 32'h8000_0000;
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          rl = 32'(q);
          rh = 32'(r);
        end
      end
      default: ;
    endcase
  endfunction

  // Launch an iterative op and check the full busy/done/hi/lo timeline.
  // inj > 0: a second start (DIVU, random operands) is sampled at edge E0+inj and must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string name, input int inj);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;                       // edge E0 passed, now in cycle E0+1
    start = 1'b0; a = $urandom; b = $urandom; // operands must already be latched
    for (int k = 1; k <= W + 1; k++) begin
      check($sformatf("%s busy c%0d", name, k), {31'h0, busy}, 32'h1);
      check($sformatf("%s done c%0d", name, k), {31'h0, done}, (k == W + 1) ? 32'h1 : 32'h0);
      if (k <= W) begin
        if (k == 1 || k == W) begin
          check($sformatf("%s hi hold c%0d", name, k), hi, mdl_hi);
          check($sformatf("%s lo hold c%0d", name, k), lo, mdl_lo);
        end
      end else begin
        check($sformatf("%s hi", name), hi, eh);
        check($sformatf("%s lo", name), lo, el);
      end
      if (inj > 0 && k == inj - 1) begin
        start = 1'b1; op = 3'b011; a = $urandom; b = $urandom_range(1, 9);
      end else if (inj > 0 && k == inj) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check($sformatf("%s busy after", name), {31'h0, busy}, 32'h0);
    check($sformatf("%s done after", name), {31'h0, done}, 32'h0);
    check($sformatf("%s hi after", name), hi, eh);
    check($sformatf("%s lo after", name), lo, el);
    mdl_hi = eh;
    mdl_lo = el;
  endtask

  initial begin
    logic [W-1:0] eh, el, x, y;
    logic [2:0]   o;

    tbl[0]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    tbl[1]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
    tbl[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
    tbl[3]  = '{3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100by7"};
    tbl[4]  = '{3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
    tbl[5]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    tbl[6]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin"};
    tbl[7]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2"};
    tbl[8]  = '{3'b010, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_by0"};
    tbl[9]  = '{3'b001, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "multu_zero"};
    tbl[10] = '{3'b010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, "div_minby1"};
    tbl[11] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_neg1sq"};

    reset = 1'b1; start = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
    mdl_hi = 32'h0; mdl_lo = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].name, 0);
    end

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("mthi busy", {31'h0, busy}, 32'h0);
    check("mthi done", {31'h0, done}, 32'h0);
    check("mthi hi", hi, 32'hDEAD_BEEF);
    check("mthi lo kept", lo, mdl_lo);
    op = 3'b101; a = 32'h0000_0005;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo busy", {31'h0, busy}, 32'h0);
    check("mtlo done", {31'h0, done}, 32'h0);
    check("mtlo hi kept", hi, 32'hDEAD_BEEF);
    check("mtlo lo", lo, 32'h0000_0005);
    mdl_hi = 32'hDEAD_BEEF; mdl_lo = 32'h0000_0005;
    @(posedge clk); #1;
    check("mtx idle busy", {31'h0, busy}, 32'h0);
    check("mtx idle done", {31'h0, done}, 32'h0);

    // Undefined ops are ignored.
    for (int i = 6; i < 8; i++) begin
      start = 1'b1; op = 3'(i); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("undef%0d busy", i), {31'h0, busy}, 32'h0);
      check($sformatf("undef%0d hi", i), hi, mdl_hi);
      check($sformatf("undef%0d lo", i), lo, mdl_lo);
      @(posedge clk); #1;
      check($sformatf("undef%0d busy2", i), {31'h0, busy}, 32'h0);
    end

    // Start while busy is ignored.
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "restart_ignored", 5);

    // Reset in the middle of an op, after an ignored second start.
    start = 1'b1; op = 3'b000; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;                      // cycle E0+1
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;                                      // cycle E0+4
    start = 1'b1; op = 3'b011; a = 32'h0000_0064; b = 32'h0000_0007;
    @(posedge clk); #1;                      // E0+5 sampled the ignored start
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;                                      // cycle E0+10
    check("midop busy before reset", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("midreset busy", {31'h0, busy}, 32'h0);
    check("midreset done", {31'h0, done}, 32'h0);
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_hi = 32'h0; mdl_lo = 32'h0;
    begin
      int seen_done, seen_busy;
      seen_done = 0; seen_busy = 0;
      for (int k = 0; k < 45; k++) begin
        if (done) seen_done++;
        if (busy) seen_busy++;
        @(posedge clk); #1;
      end
      check("postreset done pulses", 32'(seen_done), 32'h0);
      check("postreset busy cycles", 32'(seen_busy), 32'h0);
      check("postreset hi", hi, 32'h0);
      check("postreset lo", lo, 32'h0);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 15));
        2: x = 32'h8000_0000;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      ref_model(o, x, y, eh, el);
      run_op(o, x, y, eh, el, $sformatf("rand%0d_op%0d", i, o), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
